// File: rtl/potato2_ctrl.sv
// Brainfuck-style sequencer: one instruction per clk, bracket skips scan one instruction per cycle.
// IN/OUT stall in place on iowait; optional opcode-9 HALT enabled by POTATO2_HALT_EN.
module potato2_ctrl #(
  parameter int PC_W    = 8,
  parameter int DEPTH_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iowait,
  input  logic            zeroflag,
  input  logic [3:0]      instr,
  output logic [PC_W-1:0] pc,
  output logic [5:0]      command,
  output logic            halted,
  output logic            error
);

  typedef enum logic [1:0] {
    EXEC      = 2'd0,
    SKIP_FWD  = 2'd1,
    SKIP_BACK = 2'd2,
    HALT      = 2'd3
  } state_t;

  localparam logic [3:0] OP_INC  = 4'd1;
  localparam logic [3:0] OP_DEC  = 4'd2;
  localparam logic [3:0] OP_NEXT = 4'd3;
  localparam logic [3:0] OP_PREV = 4'd4;
  localparam logic [3:0] OP_OUT  = 4'd5;
  localparam logic [3:0] OP_IN   = 4'd6;
  localparam logic [3:0] OP_LOOP = 4'd7;
  localparam logic [3:0] OP_END  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;

  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_t            state;
  state_t            state_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_dec;
  logic [DEPTH_W-1:0] depth;
  logic [DEPTH_W-1:0] depth_nxt;
  logic              ovf;

  assign pc_inc = pc + PC_W'(1);
  assign pc_dec = pc - PC_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EXEC;
      pc     <= '0;
      depth  <= '0;
      halted <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      depth  <= depth_nxt;
      halted <= (state_nxt == HALT);
      error  <= error | ovf;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    depth_nxt = depth;
    command   = '0;
    ovf       = 1'b0;
    case (state)
      EXEC: begin
        case (instr)
          OP_INC:  begin command[0] = 1'b1; pc_nxt = pc_inc; end
          OP_DEC:  begin command[1] = 1'b1; pc_nxt = pc_inc; end
          OP_NEXT: begin command[2] = 1'b1; pc_nxt = pc_inc; end
          OP_PREV: begin command[3] = 1'b1; pc_nxt = pc_inc; end
          OP_OUT: begin
            command[4] = 1'b1;
            if (!iowait) pc_nxt = pc_inc;
          end
          OP_IN: begin
            command[5] = 1'b1;
            if (!iowait) pc_nxt = pc_inc;
          end
          OP_LOOP: begin
            pc_nxt = pc_inc;
            if (zeroflag) begin
              depth_nxt = DEPTH_ONE;
              state_nxt = SKIP_FWD;
            end
          end
          OP_END: begin
            if (zeroflag) begin
              pc_nxt = pc_inc;
            end else begin
              depth_nxt = DEPTH_ONE;
              pc_nxt    = pc_dec;
              state_nxt = SKIP_BACK;
            end
          end
          OP_HALT: begin
`ifdef POTATO2_HALT_EN
            state_nxt = HALT;
`else
            pc_nxt = pc_inc;
`endif
          end
          default: pc_nxt = pc_inc;
        endcase
      end

      SKIP_FWD: begin
        case (instr)
          OP_LOOP: begin
            // depth never wraps: a nest deeper than the counter freezes pc here
            if (depth == DEPTH_MAX) begin
              ovf       = 1'b1;
              state_nxt = HALT;
            end else begin
              depth_nxt = depth + DEPTH_ONE;
              pc_nxt    = pc_inc;
            end
          end
          OP_END: begin
            pc_nxt = pc_inc;
            if (depth == DEPTH_ONE) state_nxt = EXEC;
            else                    depth_nxt = depth - DEPTH_ONE;
          end
          default: pc_nxt = pc_inc;
        endcase
      end

      SKIP_BACK: begin
        case (instr)
          OP_END: begin
            if (depth == DEPTH_MAX) begin
              ovf       = 1'b1;
              state_nxt = HALT;
            end else begin
              depth_nxt = depth + DEPTH_ONE;
              pc_nxt    = pc_dec;
            end
          end
          OP_LOOP: begin
            // matching "[" found: resume on the instruction after it
            if (depth == DEPTH_ONE) begin
              pc_nxt    = pc_inc;
              state_nxt = EXEC;
            end else begin
              depth_nxt = depth - DEPTH_ONE;
              pc_nxt    = pc_dec;
            end
          end
          default: pc_nxt = pc_dec;
        endcase
      end

      default: begin
        state_nxt = HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_potato2_ctrl.sv
// Bench for potato2_ctrl: opcode vector table, directed bracket/stall/halt sequences,
// and a randomized run against a bracket-scanning reference model.
module tb_potato2_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, iowait, zeroflag;
  logic [3:0] instr;
  logic [7:0] pc;
  logic [5:0] command;
  logic       halted, error;
  logic [3:0] prog [256];
  assign instr = prog[pc];

  potato2_ctrl #(.PC_W(8), .DEPTH_W(4)) dut (
    .clk(clk), .rst(rst), .iowait(iowait), .zeroflag(zeroflag), .instr(instr),
    .pc(pc), .command(command), .halted(halted), .error(error)
  );

  logic       s_rst, s_iow, s_zf;
  logic [3:0] s_instr;
  logic [1:0] s_pc;
  logic [5:0] s_cmd;
  logic       s_halted, s_error;
  logic [3:0] s_prog [4];
  assign s_instr = s_prog[s_pc];

  potato2_ctrl #(.PC_W(2), .DEPTH_W(2)) u_small (
    .clk(clk), .rst(s_rst), .iowait(s_iow), .zeroflag(s_zf), .instr(s_instr),
    .pc(s_pc), .command(s_cmd), .halted(s_halted), .error(s_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted mid-cycle to prove it acts without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; iowait = 1'b0; zeroflag = 1'b0;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_error", error, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic expect_cyc(input string nm, input logic [7:0] epc, input logic [5:0] ecmd);
    #1;
    chk({nm, "_pc"}, pc, epc);
    chk({nm, "_cmd"}, command, ecmd);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int a = 0; a < 256; a++) prog[a] = 4'd0;
  endtask

  // ---------------- reference model ----------------
  localparam int MAXD = 15;
  int   m_pc, m_mode, m_resume;   // mode: 0 executing, 1 skipping, 2 halted
  bit   m_err, m_end_halt, lost;
  int   skipq[$];

  task automatic model_reset();
    m_pc = 0; m_mode = 0; m_err = 0; lost = 0; m_end_halt = 0;
    skipq.delete();
  endtask

  // Walk from start in direction dir looking for the matching bracket;
  // records every pc visited while skipping.
  task automatic scan(input int start, input int dir);
    int p, d, steps, deepen, close_op, op;
    p = start & 255; d = 1; steps = 0;
    deepen   = (dir > 0) ? 7 : 8;
    close_op = (dir > 0) ? 8 : 7;
    skipq.delete(); m_end_halt = 0;
    forever begin
      skipq.push_back(p);
      steps++;
      if (steps > 1000) begin lost = 1; return; end
      op = int'(prog[p]);
      if (op == deepen) begin
        if (d == MAXD) begin m_end_halt = 1; return; end
        d++;
      end else if (op == close_op) begin
        if (d == 1) begin m_resume = (p + 1) & 255; return; end
        d--;
      end
      p = (p + dir) & 255;
    end
  endtask

  task automatic gen_prog();
    int r;
    for (int a = 0; a < 256; a++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      prog[a] = 4'($urandom_range(0, 4));
      else if (r < 50) prog[a] = 4'($urandom_range(5, 6));
      else if (r < 64) prog[a] = 4'd7;
      else if (r < 78) prog[a] = 4'd8;
      else if (r < 81) prog[a] = 4'd9;
      else             prog[a] = 4'($urandom_range(10, 15));
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic       zf;
    logic       iow;
    logic [5:0] cmd;
    logic [7:0] npc;
    logic       hlt;
  } vec_t;
  vec_t tbl[17];

  initial begin
    int op;
    logic [5:0] exp_cmd;
    rst = 1'b1; iowait = 1'b0; zeroflag = 1'b0;
    s_rst = 1'b1; s_iow = 1'b0; s_zf = 1'b0;
    clear_prog();
    for (int a = 0; a < 4; a++) s_prog[a] = 4'd0;

    tbl[0]  = '{4'd0,  1'b0, 1'b0, 6'h00, 8'd1,   1'b0};
    tbl[1]  = '{4'd1,  1'b0, 1'b0, 6'h01, 8'd1,   1'b0};
    tbl[2]  = '{4'd2,  1'b0, 1'b0, 6'h02, 8'd1,   1'b0};
    tbl[3]  = '{4'd3,  1'b0, 1'b0, 6'h04, 8'd1,   1'b0};
    tbl[4]  = '{4'd4,  1'b0, 1'b0, 6'h08, 8'd1,   1'b0};
    tbl[5]  = '{4'd5,  1'b0, 1'b0, 6'h10, 8'd1,   1'b0};
    tbl[6]  = '{4'd5,  1'b0, 1'b1, 6'h10, 8'd0,   1'b0};
    tbl[7]  = '{4'd6,  1'b0, 1'b0, 6'h20, 8'd1,   1'b0};
    tbl[8]  = '{4'd6,  1'b1, 1'b1, 6'h20, 8'd0,   1'b0};
    tbl[9]  = '{4'd1,  1'b1, 1'b1, 6'h01, 8'd1,   1'b0};
    tbl[10] = '{4'd7,  1'b0, 1'b0, 6'h00, 8'd1,   1'b0};
    tbl[11] = '{4'd7,  1'b1, 1'b0, 6'h00, 8'd1,   1'b0};
    tbl[12] = '{4'd8,  1'b1, 1'b0, 6'h00, 8'd1,   1'b0};
    tbl[13] = '{4'd8,  1'b0, 1'b0, 6'h00, 8'd255, 1'b0};
`ifdef POTATO2_HALT_EN
    tbl[14] = '{4'd9,  1'b0, 1'b0, 6'h00, 8'd0,   1'b1};
`else
    tbl[14] = '{4'd9,  1'b0, 1'b0, 6'h00, 8'd1,   1'b0};
`endif
    tbl[15] = '{4'd10, 1'b0, 1'b1, 6'h00, 8'd1,   1'b0};
    tbl[16] = '{4'd15, 1'b1, 1'b0, 6'h00, 8'd1,   1'b0};

    repeat (2) @(posedge clk);

    for (int i = 0; i < 17; i++) begin
      clear_prog();
      prog[0] = tbl[i].op;
      do_reset();
      zeroflag = tbl[i].zf; iowait = tbl[i].iow;
      #1;
      chk($sformatf("vec%0d_cmd", i), command, tbl[i].cmd);
      step();
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].npc);
      chk($sformatf("vec%0d_halted", i), halted, tbl[i].hlt);
    end

    // straight-line commands
    clear_prog();
    prog[0] = 4'd1; prog[1] = 4'd1; prog[2] = 4'd3; prog[3] = 4'd2;
    do_reset();
    expect_cyc("seq0", 8'd0, 6'h01);
    expect_cyc("seq1", 8'd1, 6'h01);
    expect_cyc("seq2", 8'd2, 6'h04);
    expect_cyc("seq3", 8'd3, 6'h02);
    expect_cyc("seq4", 8'd4, 6'h00);

    // OUT stall
    clear_prog();
    prog[2] = 4'd5;
    do_reset();
    expect_cyc("io0", 8'd0, 6'h00);
    expect_cyc("io1", 8'd1, 6'h00);
    iowait = 1'b1;
    for (int k = 0; k < 3; k++) expect_cyc("io_stall", 8'd2, 6'h10);
    iowait = 1'b0;
    expect_cyc("io_go", 8'd2, 6'h10);
    expect_cyc("io_next", 8'd3, 6'h00);

    // nested forward skip
    clear_prog();
    prog[0] = 4'd7; prog[1] = 4'd7; prog[2] = 4'd1; prog[3] = 4'd8; prog[4] = 4'd8; prog[5] = 4'd1;
    do_reset();
    zeroflag = 1'b1;
    expect_cyc("fwd0", 8'd0, 6'h00);
    zeroflag = 1'b0;
    for (int k = 1; k <= 4; k++) expect_cyc("fwd_skip", 8'(k), 6'h00);
    expect_cyc("fwd_resume", 8'd5, 6'h01);

    // backward skip
    clear_prog();
    prog[0] = 4'd7; prog[1] = 4'd1; prog[2] = 4'd8;
    do_reset();
    expect_cyc("back0", 8'd0, 6'h00);
    expect_cyc("back1", 8'd1, 6'h01);
    expect_cyc("back2", 8'd2, 6'h00);
    expect_cyc("back_skip1", 8'd1, 6'h00);
    expect_cyc("back_skip0", 8'd0, 6'h00);
    expect_cyc("back_resume", 8'd1, 6'h01);

    // opcode 9
    clear_prog();
    prog[3] = 4'd9; prog[4] = 4'd1;
    do_reset();
    for (int k = 0; k < 4; k++) expect_cyc("h9_run", 8'(k), 6'h00);
`ifdef POTATO2_HALT_EN
    chk("h9_halted", halted, 1);
    expect_cyc("h9_hold", 8'd3, 6'h00);
    expect_cyc("h9_hold", 8'd3, 6'h00);
    chk("h9_halted2", halted, 1);
`else
    chk("h9_halted", halted, 0);
    expect_cyc("h9_nop", 8'd4, 6'h01);
`endif
    do_reset();
    #1;
    chk("h9_rst_pc", pc, 0);

    // depth overflow on the narrow instance
    for (int a = 0; a < 4; a++) s_prog[a] = 4'd7;
    s_zf = 1'b1;
    @(negedge clk); s_rst = 1'b1; #1;
    chk("s_rst_pc", s_pc, 0);
    @(posedge clk); #1; s_rst = 1'b0;
    repeat (4) step();
    chk("ovf_error", s_error, 1);
    chk("ovf_halted", s_halted, 1);
    chk("ovf_pc", s_pc, 3);
    s_iow = 1'b1; s_zf = 1'b0;
    repeat (3) step();
    chk("ovf_pc_frozen", s_pc, 3);
    chk("ovf_cmd", s_cmd, 0);
    for (int a = 0; a < 4; a++) s_prog[a] = 4'd0;
    @(negedge clk); s_rst = 1'b1; #1;
    chk("s_rst_error", s_error, 0);
    chk("s_rst_halted", s_halted, 0);
    @(posedge clk); #1; s_rst = 1'b0;
    repeat (4) step();
    chk("s_pc_wrap", s_pc, 0);

    // randomized run against the model
    gen_prog();
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (lost || (m_mode == 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
        gen_prog();
        do_reset();
        model_reset();
      end
      iowait   = ($urandom_range(0, 3) == 0);
      zeroflag = 1'($urandom_range(0, 1));
      #1;
      op = int'(prog[m_pc]);
      exp_cmd = 6'h00;
      if (m_mode == 0 && op >= 1 && op <= 6) exp_cmd = 6'(1 << (op - 1));
      chk("rnd_pc", pc, m_pc);
      chk("rnd_cmd", command, exp_cmd);
      chk("rnd_halted", halted, (m_mode == 2));
      chk("rnd_error", error, m_err);
      case (m_mode)
        0: begin
          case (op)
            5, 6: if (!iowait) m_pc = (m_pc + 1) & 255;
            7: begin
              if (zeroflag) begin
                scan(m_pc + 1, 1);
                m_mode = 1;
                m_pc = skipq.pop_front();
              end else m_pc = (m_pc + 1) & 255;
            end
            8: begin
              if (!zeroflag) begin
                scan(m_pc - 1, -1);
                m_mode = 1;
                m_pc = skipq.pop_front();
              end else m_pc = (m_pc + 1) & 255;
            end
`ifdef POTATO2_HALT_EN
            9: m_mode = 2;
`endif
            default: m_pc = (m_pc + 1) & 255;
          endcase
        end
        1: begin
          if (skipq.size() > 0) m_pc = skipq.pop_front();
          else if (m_end_halt) begin m_mode = 2; m_err = 1; end
          else begin m_pc = m_resume; m_mode = 0; end
        end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
